// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mem_bridge
//  Purpose  : Host-driven UART byte protocol that performs 32-bit word reads
//             and writes on a data-memory port. Frames are opcode, addr_lo,
//             addr_hi, then d0..d3 for writes. Answers ACK after a write, four
//             data bytes (LSB first) after a read, NAK for unknown opcodes.
//  Revision : 1.0  initial release
// ============================================================================
module uart_mem_bridge #(
    parameter int         ADDR_W         = 12,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              overrun
);

    // FSM encoding
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_get_addr   = 3'd1;
    localparam logic [2:0] c_st_get_data   = 3'd2;
    localparam logic [2:0] c_st_mem_wr     = 3'd3;
    localparam logic [2:0] c_st_mem_rd     = 3'd4;
    localparam logic [2:0] c_st_rd_capture = 3'd5;
    localparam logic [2:0] c_st_tx_load    = 3'd6;
    localparam logic [2:0] c_st_tx_wait    = 3'd7;

    localparam logic [7:0] c_op_write = 8'h57;
    localparam logic [7:0] c_op_read  = 8'h52;

    // Inter-byte timeout counter only needs to reach TIMEOUT_CYCLES-1
    localparam int                TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [1:0]        r_byte_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_is_write;
    logic [7:0]        r_addr_lo;
    logic [ADDR_W-1:0] r_addr_pend;   // write address held until the data is complete
    logic [23:0]       r_wbuf;        // d0..d2 of a write frame
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [23:0]       r_rd_rest;     // read bytes still to be transmitted, LSB first
    logic [1:0]        r_tx_left;
    logic [7:0]        r_tx_data;
    logic              r_tx_skip;
    logic              r_overrun;

    logic              w_timeout;
    logic              w_no_rx_state;

    assign w_timeout     = (r_tmo_cnt == c_tmo_last);
    // States in which an incoming byte cannot be taken and is reported as overrun
    assign w_no_rx_state = (r_state == c_st_mem_wr)     || (r_state == c_st_mem_rd)  ||
                           (r_state == c_st_rd_capture) || (r_state == c_st_tx_load) ||
                           (r_state == c_st_tx_wait);

    // Overrun flag: one-cycle pulse for every byte dropped while busy responding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= rx_valid && w_no_rx_state;
        end
    end

    // Main protocol FSM: frame parsing, memory access and response sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_byte_cnt  <= 2'd0;
            r_tmo_cnt   <= '0;
            r_is_write  <= 1'b0;
            r_addr_lo   <= 8'h00;
            r_addr_pend <= '0;
            r_wbuf      <= 24'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_rd_rest   <= 24'h0;
            r_tx_left   <= 2'd0;
            r_tx_data   <= 8'h00;
            r_tx_skip   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_tmo_cnt  <= '0;
                    r_byte_cnt <= 2'd0;
                    if (rx_valid) begin
                        if (rx_data == c_op_write) begin
                            r_is_write <= 1'b1;
                            r_state    <= c_st_get_addr;
                        end else if (rx_data == c_op_read) begin
                            r_is_write <= 1'b0;
                            r_state    <= c_st_get_addr;
                        end else begin
                            r_tx_data <= NAK_BYTE;
                            r_tx_left <= 2'd0;
                            r_state   <= c_st_tx_load;
                        end
                    end
                end

                c_st_get_addr: begin
                    if (rx_valid) begin
                        r_tmo_cnt <= '0;
                        if (r_byte_cnt == 2'd0) begin
                            r_addr_lo  <= rx_data;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_byte_cnt <= 2'd0;
                            // Upper address bits beyond ADDR_W are dropped silently
                            if (r_is_write) begin
                                r_addr_pend <= ADDR_W'({rx_data, r_addr_lo});
                                r_state     <= c_st_get_data;
                            end else begin
                                r_mem_addr  <= ADDR_W'({rx_data, r_addr_lo});
                                r_state     <= c_st_mem_rd;
                            end
                        end
                    end else if (w_timeout) begin
                        r_tmo_cnt <= '0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                c_st_get_data: begin
                    if (rx_valid) begin
                        r_tmo_cnt <= '0;
                        case (r_byte_cnt)
                            2'd0:    r_wbuf[7:0]   <= rx_data;
                            2'd1:    r_wbuf[15:8]  <= rx_data;
                            2'd2:    r_wbuf[23:16] <= rx_data;
                            default: begin
                                // Memory outputs only change once the whole frame is in
                                r_mem_wdata <= {rx_data, r_wbuf};
                                r_mem_addr  <= r_addr_pend;
                                r_state     <= c_st_mem_wr;
                            end
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end else if (w_timeout) begin
                        r_tmo_cnt <= '0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end

                c_st_mem_wr: begin
                    r_tx_data <= ACK_BYTE;
                    r_tx_left <= 2'd0;
                    r_state   <= c_st_tx_load;
                end

                c_st_mem_rd: begin
                    r_state <= c_st_rd_capture;
                end

                c_st_rd_capture: begin
                    r_tx_data <= mem_rdata[7:0];
                    r_rd_rest <= mem_rdata[31:8];
                    r_tx_left <= 2'd3;
                    r_state   <= c_st_tx_load;
                end

                c_st_tx_load: begin
                    // tx_start is issued combinationally in this state when the UART is free
                    if (!tx_busy) begin
                        r_tx_skip <= 1'b1;
                        r_state   <= c_st_tx_wait;
                    end
                end

                c_st_tx_wait: begin
                    // First cycle skipped: tx_busy only rises the cycle after tx_start
                    if (r_tx_skip) begin
                        r_tx_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        if (r_tx_left != 2'd0) begin
                            r_tx_data <= r_rd_rest[7:0];
                            r_rd_rest <= {8'h00, r_rd_rest[23:8]};
                            r_tx_left <= r_tx_left - 2'd1;
                            r_state   <= c_st_tx_load;
                        end else begin
                            r_state   <= c_st_idle;
                        end
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_start  = (r_state == c_st_tx_load) && !tx_busy;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = (r_state == c_st_mem_wr);
    assign mem_re    = (r_state == c_st_mem_rd);
    assign busy      = (r_state != c_st_idle);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
